// File: rtl/rom_ddram_loader_pkg.sv
// Shared types and constants for the ROM-download-to-DDRAM loader.
//   top_state_t : download sequencing (IDLE / LOAD / FLUSH)
//   wr_state_t  : DDRAM word-write handshake (W_IDLE / W_WAIT)
//   pack_word   : places the two bytes of a pair into a 16-bit word
package rom_loader_pkg;

  localparam int ADDR_W = 28;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } top_state_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_WAIT = 1'b1
  } wr_state_t;

  // swap=1: first byte lands in the high half (big-endian ROM image).
  function automatic logic [WORD_W-1:0] pack_word(input logic [7:0] first,
                                                  input logic [7:0] second,
                                                  input logic       swap);
    logic [WORD_W-1:0] w;
    if (swap) begin
      w = {first, second};
    end else begin
      w = {second, first};
    end
    return w;
  endfunction

endpackage

// File: rtl/rom_ddram_loader_if.sv
// Bus bundle between the HPS download port, the loader and the DDRAM
// controller write port.
//   ioctl_download/ioctl_wr/ioctl_dout : HPS byte stream into the loader
//   ioctl_wait                         : back-pressure to the HPS
//   wraddr/din/we_req                  : toggle-handshake word write request
//   we_ack                             : toggle acknowledge from the controller
// modport master : the loader side; modport slave : HPS + controller side.
interface rom_ddram_loader_if;
  import rom_loader_pkg::*;

  logic              ioctl_download;
  logic              ioctl_wr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] wraddr;
  logic [WORD_W-1:0] din;
  logic              we_req;
  logic              we_ack;

  modport master (
    input  ioctl_download, ioctl_wr, ioctl_dout, we_ack,
    output ioctl_wait, wraddr, din, we_req
  );

  modport slave (
    output ioctl_download, ioctl_wr, ioctl_dout, we_ack,
    input  ioctl_wait, wraddr, din, we_req
  );

endinterface

// File: rtl/rom_ddram_loader_fifo.sv
// DEPTH x WORD_W synchronous word FIFO with show-ahead head output.
//   clk, rst       : clock and asynchronous active-high reset
//   push/push_data : write a word (dropped when full and not popping)
//   pop            : remove the head word (ignored when empty)
//   head           : current oldest word, valid while !empty
//   count/full/empty : occupancy status
module word_fifo
  import rom_loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WORD_W-1:0]        push_data,
  input  logic                     pop,
  output logic [WORD_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1'b1);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinct.
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic [WORD_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign count   = wptr - rptr;
  assign full    = (count == DEPTH_CNT);
  assign empty   = (wptr == rptr);
  assign head    = mem[rptr[AW-1:0]];
  // A pop in the same cycle frees the slot, so a push into full is legal then.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  // Read/write pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= {(AW+1){1'b0}};
      rptr <= {(AW+1){1'b0}};
    end else begin
      if (do_push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (do_pop) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[AW-1:0]] <= push_data;
    end
  end

  word_fifo_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .full (full)
  );

endmodule

// File: rtl/rom_ddram_loader_fifo_chk.sv
// Simulation checker for word_fifo: flags a push into a full FIFO that is not
// relieved by a simultaneous pop (the word would be dropped).
//   clk, rst : clock and asynchronous active-high reset
//   push, pop, full : FIFO control/status being observed
module word_fifo_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic full
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop));

endmodule

// File: rtl/rom_ddram_loader.sv
// Packs the HPS download byte stream into 16-bit words, buffers them and
// writes them to the DDRAM controller with a toggle handshake.  wraddr only
// advances on acknowledge, so it doubles as the "loaded so far" watermark.
//   clk_sys, reset : system clock, asynchronous active-high reset
//   bus (master)   : ioctl_* download port and wraddr/din/we_req/we_ack
//   rom_size       : byte count of the last completed download
//   busy           : download or drain in progress
//   done           : one-cycle pulse when the last word has been acknowledged
module rom_ddram_loader
  import rom_loader_pkg::*;
#(
  parameter int         DEPTH      = 4,
  parameter bit         SWAP_BYTES = 1'b1,
  parameter logic [7:0] PAD_BYTE   = 8'hFF
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  rom_ddram_loader_if.master   bus,
  output logic [ADDR_W-1:0]    rom_size,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]     NEAR_FULL  = CW'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(2'd2);
  localparam logic [ADDR_W-1:0] COUNT_STEP = ADDR_W'(1'b1);

  top_state_t        state;
  top_state_t        state_next;
  wr_state_t         wstate;
  wr_state_t         wstate_next;

  logic              phase;
  logic [7:0]        hold;
  logic [ADDR_W-1:0] byte_count;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              wr_req;
  logic              hps_wait;

  logic              load_entry;
  logic              flush_exit;
  logic              byte_wr;
  logic              pad_push;
  logic              push;
  logic [WORD_W-1:0] push_data;
  logic              pop;
  logic              issue;
  logic [WORD_W-1:0] head;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;

  assign bus.wraddr     = wr_addr;
  assign bus.din        = wr_data;
  assign bus.we_req     = wr_req;
  assign bus.ioctl_wait = hps_wait;

  word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk_sys),
    .rst       (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Top FSM state register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Top FSM next state, byte packing and FIFO push.
  // In IDLE the download level (not its edge) starts a load, which also picks
  // up a rising edge that arrived while still draining in FLUSH.
  always_comb begin
    state_next = state;
    load_entry = 1'b0;
    flush_exit = 1'b0;
    byte_wr    = 1'b0;
    pad_push   = 1'b0;
    push       = 1'b0;
    push_data  = {WORD_W{1'b0}};
    case (state)
      IDLE: begin
        if (bus.ioctl_download) begin
          state_next = LOAD;
          load_entry = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      LOAD: begin
        if (!bus.ioctl_download) begin
          state_next = FLUSH;
          if (phase) begin
            pad_push  = 1'b1;
            push      = 1'b1;
            push_data = pack_word(hold, PAD_BYTE, SWAP_BYTES);
          end else begin
            pad_push  = 1'b0;
          end
        end else if (bus.ioctl_wr) begin
          byte_wr = 1'b1;
          if (phase) begin
            push      = 1'b1;
            push_data = pack_word(hold, bus.ioctl_dout, SWAP_BYTES);
          end else begin
            push      = 1'b0;
          end
        end else begin
          byte_wr = 1'b0;
        end
      end
      FLUSH: begin
        if (empty && (wr_req == bus.we_ack)) begin
          state_next = IDLE;
          flush_exit = 1'b1;
        end else begin
          state_next = FLUSH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Write FSM state register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wstate <= W_IDLE;
    end else begin
      wstate <= wstate_next;
    end
  end

  // Write FSM: issue the head word, then pop it once the toggle is returned.
  always_comb begin
    wstate_next = wstate;
    issue       = 1'b0;
    pop         = 1'b0;
    case (wstate)
      W_IDLE: begin
        if (!empty) begin
          issue       = 1'b1;
          wstate_next = W_WAIT;
        end else begin
          wstate_next = W_IDLE;
        end
      end
      W_WAIT: begin
        if (bus.we_ack == wr_req) begin
          pop         = 1'b1;
          wstate_next = W_IDLE;
        end else begin
          wstate_next = W_WAIT;
        end
      end
      default: begin
        wstate_next = W_IDLE;
      end
    endcase
  end

  // Byte-phase, holding register and byte counter.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      phase      <= 1'b0;
      hold       <= 8'h00;
      byte_count <= {ADDR_W{1'b0}};
    end else if (load_entry) begin
      phase      <= 1'b0;
      byte_count <= {ADDR_W{1'b0}};
    end else if (byte_wr) begin
      phase      <= ~phase;
      byte_count <= byte_count + COUNT_STEP;
      if (!phase) begin
        hold <= bus.ioctl_dout;
      end
    end else if (pad_push) begin
      phase <= 1'b0;
    end
  end

  // DDRAM write request registers; wraddr moves only after acknowledge.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_addr <= {ADDR_W{1'b0}};
      wr_data <= {WORD_W{1'b0}};
      wr_req  <= 1'b0;
    end else begin
      if (load_entry) begin
        wr_addr <= {ADDR_W{1'b0}};
      end else if (pop) begin
        wr_addr <= wr_addr + ADDR_STEP;
      end
      if (issue) begin
        wr_data <= head;
        wr_req  <= ~wr_req;
      end
    end
  end

  // Status outputs.  ioctl_wait reacts to occupancy one cycle late, so it
  // raises with one free slot left to absorb the byte already in flight.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      hps_wait <= 1'b0;
      rom_size <= {ADDR_W{1'b0}};
    end else begin
      busy     <= (state_next != IDLE);
      done     <= flush_exit;
      hps_wait <= busy & ((state == FLUSH) | full | (count == NEAR_FULL));
      if (flush_exit) begin
        rom_size <= byte_count;
      end
    end
  end

endmodule

// File: tb/tb_rom_ddram_loader.sv
// Self-checking bench for rom_ddram_loader: a byte-list model of the expected
// word stream is checked on every write-request toggle and at every done pulse,
// alongside literal expectations per directed download.
module tb_rom_ddram_loader;
  import rom_loader_pkg::*;

  logic clk_sys = 1'b0;
  logic reset   = 1'b0;

  initial forever #5 clk_sys = ~clk_sys;

  rom_ddram_loader_if bus_a ();
  rom_ddram_loader_if bus_b ();

  logic [ADDR_W-1:0] rom_size_a, rom_size_b;
  logic busy_a, done_a, busy_b, done_b;

  rom_ddram_loader #(.DEPTH(4), .SWAP_BYTES(1'b1), .PAD_BYTE(8'hFF)) dut_a (
    .clk_sys (clk_sys), .reset (reset), .bus (bus_a),
    .rom_size (rom_size_a), .busy (busy_a), .done (done_a)
  );

  rom_ddram_loader #(.DEPTH(4), .SWAP_BYTES(1'b0), .PAD_BYTE(8'hFF)) dut_b (
    .clk_sys (clk_sys), .reset (reset), .bus (bus_b),
    .rom_size (rom_size_b), .busy (busy_b), .done (done_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [7:0]  tx[$];
  logic [15:0] exp_words[$];
  int          exp_bytes  = 0;
  int          exp_nwords = 0;

  task automatic build_model(input bit swap);
    logic [7:0] a, b;
    exp_bytes  = tx.size();
    exp_nwords = (tx.size() + 1) / 2;
    for (int i = 0; i < tx.size(); i += 2) begin
      a = tx[i];
      b = (i + 1 < tx.size()) ? tx[i+1] : 8'hFF;
      exp_words.push_back(swap ? {a, b} : {b, a});
    end
  endtask

  // ---------------- controller ack model ----------------
  int ack_delay = 2;
  int ack_cnt   = 0;

  initial begin
    bus_a.we_ack = 1'b0;
    forever begin
      @(posedge clk_sys); #1;
      if (reset) begin
        bus_a.we_ack = 1'b0;
        ack_cnt = 0;
      end else if (bus_a.we_req != bus_a.we_ack) begin
        if (ack_cnt >= ack_delay) begin
          bus_a.we_ack = bus_a.we_req;
          ack_cnt = 0;
        end else begin
          ack_cnt++;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  logic        prev_req = 1'b0;
  int          idx = 0;
  int          done_count = 0;
  bit          saw_wait = 1'b0;
  logic [27:0] cur_addr;
  logic [15:0] cur_din;
  logic [27:0] log_addr[$];
  logic [15:0] log_din[$];

  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        prev_req = 1'b0;
        idx = 0;
        exp_words.delete();
      end else begin
        if (bus_a.ioctl_wait) saw_wait = 1'b1;
        if (bus_a.we_req != prev_req) begin
          prev_req = bus_a.we_req;
          cur_addr = bus_a.wraddr;
          cur_din  = bus_a.din;
          log_addr.push_back(bus_a.wraddr);
          log_din.push_back(bus_a.din);
          if (exp_words.size() == 0) begin
            check("unexpected_word", exp_words.size(), 1);
          end else begin
            e = exp_words.pop_front();
            check("din", bus_a.din, e);
            check("wraddr", bus_a.wraddr, 2 * idx);
          end
          idx++;
        end else if (bus_a.we_req != bus_a.we_ack) begin
          check("din_stable", bus_a.din, cur_din);
          check("wraddr_stable", bus_a.wraddr, cur_addr);
        end
        if (done_a) begin
          done_count++;
          check("rom_size", rom_size_a, exp_bytes);
          check("final_wraddr", bus_a.wraddr, 2 * idx);
          check("words_written", idx, exp_nwords);
          check("words_left", exp_words.size(), 0);
          idx = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int abort_word, output bit aborted);
    int guard;
    aborted = 1'b0;
    bus_a.ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    foreach (tx[i]) begin
      guard = 0;
      while (bus_a.ioctl_wait && guard < 2000 &&
             !(abort_word > 0 && idx == abort_word && bus_a.we_req != bus_a.we_ack)) begin
        @(posedge clk_sys); #1;
        guard++;
      end
      if (guard >= 2000) check("ioctl_wait_timeout", guard, 0);
      if (abort_word > 0 && idx == abort_word && bus_a.we_req != bus_a.we_ack) begin
        aborted = 1'b1;
        return;
      end
      bus_a.ioctl_wr   = 1'b1;
      bus_a.ioctl_dout = tx[i];
      @(posedge clk_sys); #1;
      bus_a.ioctl_wr   = 1'b0;
    end
    bus_a.ioctl_download = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int guard = 0;
    while (done_count == d0 && guard < 3000) begin
      @(posedge clk_sys); #1;
      guard++;
    end
    check("done_seen", done_count - d0, 1);
  endtask

  task automatic idle_check(input int d0, input string tag);
    repeat (3) @(posedge clk_sys);
    #1;
    check({tag, "_one_done"}, done_count - d0, 1);
    check({tag, "_busy_low"}, busy_a, 1'b0);
    check({tag, "_wait_low"}, bus_a.ioctl_wait, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wraddr"}, bus_a.wraddr, 0);
    check({tag, "_din"}, bus_a.din, 0);
    check({tag, "_we_req"}, bus_a.we_req, 0);
    check({tag, "_wait"}, bus_a.ioctl_wait, 0);
    check({tag, "_rom_size"}, rom_size_a, 0);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_done"}, done_a, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int d0, base, guard;
    bit ab;
    bus_a.ioctl_download = 1'b0; bus_a.ioctl_wr = 1'b0; bus_a.ioctl_dout = 8'h00;
    bus_b.ioctl_download = 1'b0; bus_b.ioctl_wr = 1'b0; bus_b.ioctl_dout = 8'h00;
    bus_b.we_ack = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk_sys); #1;

    // 1: four bytes, even length, big-endian
    tx = '{8'h11, 8'h22, 8'h33, 8'h44};
    build_model(1'b1);
    base = log_din.size(); d0 = done_count; ack_delay = 2;
    send(0, ab); wait_done(d0);
    check("t1_w0_din", log_din[base], 16'h1122);
    check("t1_w0_addr", log_addr[base], 28'd0);
    check("t1_w1_din", log_din[base+1], 16'h3344);
    check("t1_w1_addr", log_addr[base+1], 28'd2);
    check("t1_rom_size", rom_size_a, 28'd4);
    check("t1_wraddr", bus_a.wraddr, 28'd4);
    idle_check(d0, "t1");

    // 2: odd length gets a pad byte
    tx = '{8'hAA, 8'hBB, 8'hCC};
    build_model(1'b1);
    base = log_din.size(); d0 = done_count;
    send(0, ab); wait_done(d0);
    check("t2_w0_din", log_din[base], 16'hAABB);
    check("t2_w1_din", log_din[base+1], 16'hCCFF);
    check("t2_rom_size", rom_size_a, 28'd3);
    check("t2_wraddr", bus_a.wraddr, 28'd4);
    idle_check(d0, "t2");

    // 3: slow controller, back-to-back bytes, back-pressure
    tx.delete();
    for (int i = 0; i < 16; i++) tx.push_back(8'(8'h10 + i));
    build_model(1'b1);
    base = log_din.size(); d0 = done_count; ack_delay = 50; saw_wait = 1'b0;
    send(0, ab); wait_done(d0);
    check("t3_saw_wait", saw_wait, 1'b1);
    check("t3_nwords", log_din.size() - base, 8);
    check("t3_w7_din", log_din[base+7], 16'h1E1F);
    check("t3_w7_addr", log_addr[base+7], 28'd14);
    check("t3_rom_size", rom_size_a, 28'd16);
    check("t3_wraddr", bus_a.wraddr, 28'd16);
    idle_check(d0, "t3");

    // 4: reset while word 3 awaits acknowledge
    tx.delete();
    for (int i = 0; i < 16; i++) tx.push_back(8'(8'h80 + i));
    build_model(1'b1);
    ack_delay = 20;
    send(3, ab);
    check("t4_abort_reached", ab, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    bus_a.ioctl_download = 1'b0; bus_a.ioctl_wr = 1'b0;
    @(posedge clk_sys); @(posedge clk_sys); #1;
    reset = 1'b0;
    ack_delay = 2;
    @(posedge clk_sys); #1;

    // 5: short download after reset starts at address 0
    tx = '{8'h5A, 8'hA5};
    build_model(1'b1);
    base = log_din.size(); d0 = done_count;
    send(0, ab); wait_done(d0);
    check("t5_w0_din", log_din[base], 16'h5AA5);
    check("t5_w0_addr", log_addr[base], 28'd0);
    check("t5_rom_size", rom_size_a, 28'd2);

    // 6: immediate second download; rom_size holds until its done
    tx = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    build_model(1'b1);
    base = log_din.size(); d0 = done_count;
    send(0, ab);
    check("t6_rom_size_held", rom_size_a, 28'd2);
    wait_done(d0);
    check("t6_w0_din", log_din[base], 16'hC1C2);
    check("t6_w0_addr", log_addr[base], 28'd0);
    check("t6_rom_size", rom_size_a, 28'd4);
    idle_check(d0, "t6");

    // 7: little-endian instance
    bus_b.ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    bus_b.ioctl_wr = 1'b1; bus_b.ioctl_dout = 8'h01;
    @(posedge clk_sys); #1;
    bus_b.ioctl_dout = 8'h02;
    @(posedge clk_sys); #1;
    bus_b.ioctl_wr = 1'b0; bus_b.ioctl_download = 1'b0;
    guard = 0;
    while (bus_b.we_req == 1'b0 && guard < 50) begin
      @(posedge clk_sys); #1; guard++;
    end
    check("t7_req_toggled", bus_b.we_req, 1'b1);
    check("t7_din", bus_b.din, 16'h0201);
    check("t7_wraddr_inflight", bus_b.wraddr, 28'd0);
    bus_b.we_ack = 1'b1;
    guard = 0;
    while (done_b == 1'b0 && guard < 50) begin
      @(posedge clk_sys); #1; guard++;
    end
    check("t7_done", done_b, 1'b1);
    check("t7_rom_size", rom_size_b, 28'd2);
    check("t7_wraddr", bus_b.wraddr, 28'd2);
    repeat (2) @(posedge clk_sys);
    #1;
    check("t7_busy_low", busy_b, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
